// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: sequences a W-bit count register through up-wrap, down-wrap or bounce passes
// between programmable limits, under control of a valid/ready host command port.
module cnt_seq_ctrl #(
    parameter int W  = 4,
    parameter int PW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cfg_mode,
    input  logic [W-1:0]  cfg_lo,
    input  logic [W-1:0]  cfg_hi,
    input  logic [PW-1:0] cfg_passes,
    output logic [W-1:0]  sa,
    output logic          dir,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;
    localparam logic [1:0] M_UP     = 2'b00;
    localparam logic [1:0] M_DOWN   = 2'b01;

    state_t        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d, lo_q, lo_d, hi_q, hi_d, step_sa;
    logic [PW-1:0] pass_q, pass_d, passes_q, passes_d;
    logic [1:0]    mode_q, mode_d;
    logic          dir_q, dir_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          acc, start, pause, stop, cfg_bad, lo_eq_hi, term, fin, step_dir;

    assign cmd_ready = state_q != LOAD;
    assign sa        = sa_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        acc      = cmd_valid && cmd_ready;
        start    = acc && cmd_op == OP_START;
        pause    = acc && cmd_op == OP_PAUSE;
        stop     = acc && cmd_op == OP_STOP;
        cfg_bad  = cfg_lo > cfg_hi || cfg_mode == 2'b11;
        lo_eq_hi = lo_q == hi_q;
        term     = mode_q == M_UP   ? sa_q == hi_q :
                   mode_q == M_DOWN ? sa_q == lo_q :
                   lo_eq_hi || (dir_q && sa_q == lo_q);
        fin      = term && passes_q != '0 && pass_q + PW'(1) == passes_q;
        // Bounce turns at hi without counting it as a terminal; the pass ends back at lo.
        step_sa  = mode_q == M_UP   ? (term ? lo_q : sa_q + W'(1)) :
                   mode_q == M_DOWN ? (term ? hi_q : sa_q - W'(1)) :
                   term             ? (lo_eq_hi ? sa_q : lo_q + W'(1)) :
                   (!dir_q && sa_q == hi_q) ? hi_q - W'(1) :
                   dir_q            ? sa_q - W'(1) : sa_q + W'(1);
        step_dir = mode_q == M_UP   ? 1'b0 :
                   mode_q == M_DOWN ? 1'b1 :
                   term             ? 1'b0 :
                   (!dir_q && sa_q == hi_q) ? 1'b1 : dir_q;
        state_d  = state_q;
        sa_d     = sa_q;
        dir_d    = dir_q;
        pass_d   = pass_q;
        mode_d   = mode_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        passes_d = passes_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    sa_d    = '0;
                    dir_d   = 1'b0;
                    pass_d  = '0;
                end else if (start && cfg_bad) begin
                    err_d = 1'b1;
                end else if (start) begin
                    state_d  = LOAD;
                    mode_d   = cfg_mode;
                    lo_d     = cfg_lo;
                    hi_d     = cfg_hi;
                    passes_d = cfg_passes;
                    pass_d   = '0;
                end
            end
            LOAD: begin
                state_d = RUN;
                sa_d    = mode_q == M_DOWN ? hi_q : lo_q;
                dir_d   = mode_q == M_DOWN;
            end
            RUN: begin
                err_d = start;
                if (stop) begin
                    state_d = IDLE;
                    sa_d    = '0;
                    dir_d   = 1'b0;
                    pass_d  = '0;
                end else if (fin) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    sa_d   = step_sa;
                    dir_d  = step_dir;
                    pass_d = term ? pass_q + PW'(1) : pass_q;
                end
            end
            PAUSE: begin
                err_d = start;
                if (stop) begin
                    state_d = IDLE;
                    sa_d    = '0;
                    dir_d   = 1'b0;
                    pass_d  = '0;
                end else if (pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == LOAD || state_d == RUN || state_d == PAUSE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            dir_q    <= 1'b0;
            pass_q   <= '0;
            mode_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            passes_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            dir_q    <= dir_d;
            pass_q   <= pass_d;
            mode_q   <= mode_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            passes_q <= passes_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
endmodule
